// File: rtl/ctrl_pipe_stage.sv
// Elastic multi-stage pipeline register for the decode-to-execute control bundle.
// Optional back-pressure statistics counter enabled by defining CTRL_PIPE_STATS_EN.
module ctrl_pipe_stage #(
    parameter int               WIDTH     = 11,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] KILL_MASK = WIDTH'(11'h218)
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef CTRL_PIPE_STATS_EN
    ,
    output logic [15:0]                stall_cnt
`endif
);

    localparam int OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] v_d;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];
    logic [DEPTH-1:0] acc;
    logic [DEPTH-1:0] up_v;
    logic [WIDTH-1:0] up_d [DEPTH];

    // A stage can accept when any stage at or beyond it is empty, or downstream drains.
    always_comb begin
        logic run;
        run = out_ready;
        acc = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            run    = run | ~v_q[i];
            acc[i] = run;
        end
    end

    assign in_ready = acc[0] & ~flush;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_up
            if (gi == 0) begin : g_head
                assign up_v[gi] = in_valid & in_ready;
                assign up_d[gi] = in_data;
            end else begin : g_body
                assign up_v[gi] = v_q[gi-1];
                assign up_d[gi] = d_q[gi-1];
            end
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            v_d[i] = v_q[i];
            d_d[i] = d_q[i];
            if (flush) begin
                v_d[i] = 1'b0;
            end else if (acc[i]) begin
                v_d[i] = up_v[i];
                if (up_v[i]) begin
                    d_d[i] = up_d[i];
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            v_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d_q[i] <= '0;
            end
        end else begin
            v_q <= v_d;
            for (int i = 0; i < DEPTH; i++) begin
                d_q[i] <= d_d[i];
            end
        end
    end

    assign out_valid = v_q[DEPTH-1];
    assign out_data  = v_q[DEPTH-1] ? d_q[DEPTH-1] : (d_q[DEPTH-1] & ~KILL_MASK);

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(v_q[i]);
        end
    end

`ifdef CTRL_PIPE_STATS_EN
    logic [15:0] stall_q;
    logic [15:0] stall_d;

    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && !flush && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule
